mul_seq: RTL and testbench

Parametrised sequential shift-add multiplier: WIDTH x WIDTH operands give a 2*WIDTH product. It supports unsigned and two's-complement signed modes, selected per operation.
- Replaces fixed-size gate-level multipliers in the FPGA example designs wherever operand width grows and area matters more than latency.
- Start/busy/done handshake, one radix-2 iteration per clock.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/mul_seq_dp.sv | 87 ++++++++
 rtl/mul_seq.sv | 87 ++++++++
 tb/tb_mul_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MAG_W = 32;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    // Two's-complement magnitude; caller zero-extends and truncates back.
    function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v,
                                                  input logic             is_neg);
        return is_neg ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Multiplier datapath: operand capture, radix-2 add/shift accumulator and
// final sign correction into the product register.
module mul_seq_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               finish_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned UW    = WIDTH + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    p_q, p_d;

    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic [UW-1:0]    upper_c;
    logic [ACC_W-1:0] acc_add_c, acc_sh_c;
    logic [PW-1:0]    prod_c, p_fix_c;

    assign a_neg_c = signed_mode_i & a_i[WIDTH-1];
    assign b_neg_c = signed_mode_i & b_i[WIDTH-1];
    assign a_mag_c = WIDTH'(twos_mag(MAG_W'(a_i), a_neg_c));
    assign b_mag_c = WIDTH'(twos_mag(MAG_W'(b_i), b_neg_c));

    // One iteration: conditional add into the upper half (carry in the extra bit), then shift.
    always_comb begin
        upper_c   = UW'(acc_q[ACC_W-1:WIDTH]) + UW'(mcand_q);
        acc_add_c = mplier_q[0] ? {upper_c, acc_q[WIDTH-1:0]} : acc_q;
        acc_sh_c  = acc_add_c >> 1;
        prod_c    = acc_sh_c[PW-1:0];
        p_fix_c   = neg_q ? (~prod_c + PW'(1)) : prod_c;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        p_d      = p_q;
        if (load_i) begin
            mcand_d  = a_mag_c;
            mplier_d = b_mag_c;
            acc_d    = '0;
            neg_d    = a_neg_c ^ b_neg_c;
        end else if (step_i) begin
            acc_d    = acc_sh_c;
            mplier_d = mplier_q >> 1;
        end
        if (finish_i) begin
            p_d = p_fix_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier top: FSM, iteration counter and
// start/busy/done handshake around the mul_seq_dp datapath.
module mul_seq
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c, step_c, finish_c;

    // Next state and datapath controls; DONE accepts a new start like IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                step_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    finish_c = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_i        (load_c),
        .step_i        (step_c),
        .finish_i      (finish_c),
        .signed_mode_i (signed_mode),
        .a_i           (a),
        .b_i           (b),
        .p_o           (p)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq at WIDTH 2, 8 and 16 against an integer-arithmetic product model.
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        start2, sm2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int total = 0;
    int passed = 0;
    int failed = 0;

    mul_seq #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .p(p2));
    mul_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .p(p8));
    mul_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .p(p16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact product from signed/unsigned integer interpretation, masked to 2*w bits.
    function automatic longint unsigned ref_mul(input longint unsigned av, input longint unsigned bv,
                                                input int w, input bit s);
        longint unsigned m = (64'd1 << w) - 64'd1;
        longint sa;
        longint sb;
        longint prod;
        av = av & m;
        bv = bv & m;
        sa = longint'(av);
        sb = longint'(bv);
        if (s && av[w-1]) sa = sa - longint'(64'd1 << w);
        if (s && bv[w-1]) sb = sb - longint'(64'd1 << w);
        prod = sa * sb;
        return longint'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic set_in(input int sel, input logic st, input longint unsigned av,
                          input longint unsigned bv, input logic s);
        case (sel)
            2:  begin start2  = st; a2  = 2'(av);  b2  = 2'(bv);  sm2  = s; end
            8:  begin start8  = st; a8  = 8'(av);  b8  = 8'(bv);  sm8  = s; end
            default: begin start16 = st; a16 = 16'(av); b16 = 16'(bv); sm16 = s; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic bz, output logic dn, output logic [63:0] pv);
        case (sel)
            2:  begin bz = busy2;  dn = done2;  pv = 64'(p2);  end
            8:  begin bz = busy8;  dn = done8;  pv = 64'(p8);  end
            default: begin bz = busy16; dn = done16; pv = 64'(p16); end
        endcase
    endtask

    // One operation: operands are scrambled after acceptance; optional stray start pulse.
    task automatic run_op(input int sel, input longint unsigned av, input longint unsigned bv,
                          input bit s, input longint unsigned exp, input int pulse_at,
                          input string tag);
        logic        bz, dn;
        logic [63:0] pv, p0;
        int          lat;
        bit          stable;
        @(negedge clk);
        set_in(sel, 1'b1, av, bv, s);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 64'($urandom), 64'($urandom), ~s);
        get_out(sel, bz, p0[0], p0);
        get_out(sel, bz, dn, p0);
        chk({tag, " busy_after_start"}, 64'(bz), 64'd1);
        lat = 0;
        stable = 1'b1;
        dn = 1'b0;
        while (!dn && lat < 100) begin
            if (lat == pulse_at) set_in(sel, 1'b1, 64'($urandom), 64'($urandom), ~s);
            @(posedge clk);
            #1;
            if (lat == pulse_at) set_in(sel, 1'b0, 64'($urandom), 64'($urandom), s);
            lat++;
            get_out(sel, bz, dn, pv);
            if (!dn && pv !== p0) stable = 1'b0;
        end
        chk({tag, " latency"}, 64'(lat), 64'(sel));
        chk({tag, " busy_at_done"}, 64'(bz), 64'd0);
        chk({tag, " product"}, pv, exp);
        chk({tag, " p_held_while_busy"}, 64'(stable), 64'd1);
        @(posedge clk);
        #1;
        get_out(sel, bz, dn, pv);
        chk({tag, " done_one_cycle"}, 64'(dn), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] exp;
    } vec8_t;

    initial begin
        vec8_t       dir [6];
        int          lat, gap, ndone;
        longint unsigned ra, rb;
        bit          rs;

        dir[0] = '{8'd3,   8'd5,   1'b0, 16'h000F};
        dir[1] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        dir[2] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        dir[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
        dir[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        dir[5] = '{8'd127, 8'h80,  1'b1, 16'hC080};

        set_in(2, 1'b0, 0, 0, 1'b0);
        set_in(8, 1'b0, 0, 0, 1'b0);
        set_in(16, 1'b0, 0, 0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset p", 64'(p8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(8, 64'(dir[i].a), 64'(dir[i].b), dir[i].s, 64'(dir[i].exp), -1,
                   $sformatf("dir%0d", i));

        run_op(8, 64'd10, 64'd11, 1'b0, 64'd110, 2, "ignored_start");

        // Back-to-back: start held high; second operands presented while first is busy.
        @(negedge clk);
        set_in(8, 1'b1, 64'd20, 64'd3, 1'b0);
        @(posedge clk);
        #1;
        a8 = 8'd7;
        b8 = 8'd9;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b first latency", 64'(lat), 64'd8);
        chk("b2b first product", 64'(p8), 64'd60);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b second accepted", 64'(busy8), 64'd1);
        gap = 1;
        while (!done8 && gap < 40) begin
            @(posedge clk);
            #1;
            gap++;
        end
        chk("b2b done spacing", 64'(gap), 64'd9);
        chk("b2b second product", 64'(p8), 64'd63);
        @(posedge clk);
        #1;
        chk("b2b idle after", 64'(busy8 | done8), 64'd0);

        // Asynchronous abort mid-calculation.
        @(negedge clk);
        set_in(8, 1'b1, 64'd200, 64'd200, 1'b0);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy8), 64'd0);
        chk("abort done", 64'(done8), 64'd0);
        chk("abort p", 64'(p8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);
        run_op(8, 64'd6, 64'd7, 1'b0, 64'd42, -1, "after_abort");

        for (int i = 0; i < 100; i++) begin
            ra = 64'($urandom);
            rb = 64'($urandom);
            rs = 1'($urandom);
            run_op(8, ra, rb, rs, ref_mul(ra, rb, 8, rs), -1, $sformatf("rnd8_%0d", i));
        end

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    run_op(2, 64'(x), 64'(y), 1'(m), ref_mul(64'(x), 64'(y), 2, 1'(m)), -1,
                           $sformatf("w2_m%0d_%0d_%0d", m, x, y));

        for (int i = 0; i < 1000; i++) begin
            ra = 64'($urandom);
            rb = 64'($urandom);
            rs = 1'($urandom);
            run_op(16, ra, rb, rs, ref_mul(ra, rb, 16, rs), -1, $sformatf("rnd16_%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
